fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Instruction fetch/execute sequencer upstream of the 2-to-4 register-select decoder.
//   - Fetches 8-bit instructions from memory over a req/ack handshake.
//   - Executes NOP/SEL/JMP/HALT.
//   - On SEL, drives the decoder select pair (a, b) with a one-cycle sel_valid strobe.
// PARAMETERS
//   ADDR_W   8   program counter / memory address width
//   TIMEOUT  15  max cycles in FETCH without ack; used only when FETCH_CTRL_TIMEOUT_EN is defined
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active-high
//   run        in   1       1 = keep fetching; 0 = stop after current instruction
//   mem_req    out  1       fetch request
//   mem_addr   out  ADDR_W  fetch address (= pc)
//   mem_ack    in   1       memory ack; mem_rdata valid in the same cycle
//   mem_rdata  in   8       instruction word
//   a          out  1       decoder select MSB (instr[5])
//   b          out  1       decoder select LSB (instr[4])
//   sel_valid  out  1       one-cycle strobe: a/b were just updated by SEL
//   imm        out  4       imm field of last SEL
//   pc         out  ADDR_W  program counter
//   busy       out  1       1 when state != IDLE and state != HALTED
//   halted     out  1       1 in HALTED
//   err        out  1       fetch timeout flag (tied 0 without macro)
// BEHAVIOUR
//   Reset: all outputs 0, pc=0, ir=0, state=IDLE. Reset is async.
//   Reset mid-fetch drops mem_req immediately, with no memory transaction completed.
//   Instruction: [7:6] op, [5:4] dest {a,b}, [3:0] imm.
//   Opcodes: 00 NOP, 01 SEL, 10 JMP, 11 HALT.
//   FSM states IDLE, FETCH, EXEC, HALTED:
//   - IDLE: run=1 -> FETCH; else stay.
//   - FETCH: mem_req=1 and mem_addr=pc, both registered.
//     Held stable until mem_ack is sampled high.
//     On that edge: ir<=mem_rdata, mem_req<=0, -> EXEC.
//   - EXEC (exactly one cycle):
//     NOP  pc<=pc+1.
//     SEL  {a,b}<=ir[5:4]; imm<=ir[3:0]; sel_valid<=1; pc<=pc+1.
//     JMP  pc<=zero-extended ir[3:0].
//     HALT pc unchanged; -> HALTED.
//     Non-HALT ops: run=1 -> FETCH, run=0 -> IDLE.
//   - HALTED: mem_req=0; run ignored; only rst exits.
//   sel_valid: high for exactly the one cycle after an EXEC of SEL; 0 otherwise.
//   a, b, imm: hold their last value between SELs.
//   pc arithmetic: pc+1 wraps modulo 2^ADDR_W (all-ones -> 0).
//   Latency with zero-wait ack: 2 cycles per instruction (FETCH + EXEC).
//   Back-to-back SELs therefore give sel_valid every 2nd cycle.
//   mem_ack outside FETCH is ignored.
//   run falling during FETCH: fetch completes and EXEC runs, then -> IDLE.
// CONFIGURATION
//   FETCH_CTRL_TIMEOUT_EN defined:
//   - A counter counts cycles in FETCH without ack.
//   - Reaching TIMEOUT forces: mem_req<=0, err<=1, state->HALTED.
//   - err is sticky until rst.
//   - An ack in the same cycle the count reaches TIMEOUT wins: normal fetch.
//   FETCH_CTRL_TIMEOUT_EN undefined:
//   - No counter; FETCH waits indefinitely; err is constant 0.
// TESTING
//   1. rst=1 during FETCH -> mem_req, a, b, sel_valid, pc, busy, halted, err all 0 before next clk edge.
//   2. run=1, addr0 returns 8'h60 with zero-wait ack -> a=1, b=0, imm=0, sel_valid high 1 cycle, pc=1, mem_addr=1 next fetch.
//   3. addr1=8'h85 (JMP 5) -> pc=5, next mem_addr=5.
//      Then ADDR_W=8 with pc=8'hFF running NOP -> pc=0.
//   4. ack delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles, ir unchanged, sel_valid stays 0.
//   5. 8'hC0 (HALT) with run=1 -> halted=1, busy=0, mem_req stays 0 for 20 cycles; rst returns to IDLE.
//   6. Macro defined, TIMEOUT=15, no ack -> err=1 and halted=1 after 15 FETCH cycles.
//      Without macro: still in FETCH after 100 cycles.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch/execute sequencer feeding the 2-to-4 register-select decoder.
// Fetches 8-bit instructions over a req/ack handshake and executes NOP/SEL/JMP/HALT.
// Instruction format: [7:6] op, [5:4] dest {a,b}, [3:0] imm.
// Optional feature: define FETCH_CTRL_TIMEOUT_EN to bound the wait for mem_ack. After TIMEOUT
// FETCH cycles with no ack the sequencer halts and raises a sticky err. In the default build
// FETCH waits indefinitely and err is constant 0.
module fetch_ctrl #(
  parameter int ADDR_W = 8
`ifdef FETCH_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              a,
  output logic              b,
  output logic              sel_valid,
  output logic [3:0]        imm,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_SEL, OP_JMP, OP_HALT} op_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [7:0]        ir_q;
  logic              a_q;
  logic              b_q;
  logic [3:0]        imm_q;
  logic              sel_valid_q;
  logic              mem_req_q;
  op_t               op;

`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  assign op = op_t'(ir_q[7:6]);

  // Next program counter for the instruction held in ir; applied only in EXEC.
  always_comb begin
    // NOTE: assign a default first so no path through the case leaves pc_d unassigned (no latch).
    pc_d = pc_q;
    case (op)
      OP_NOP, OP_SEL: pc_d = pc_q + ADDR_W'(1);
      OP_JMP:         pc_d = ADDR_W'(ir_q[3:0]);
      default:        pc_d = pc_q;
    endcase
  end

  // Sequencer FSM; every output comes straight from a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: async reset clears every register, ir included, so mem_req drops without waiting for a clock.
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      imm_q       <= '0;
      sel_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every branch sees the pre-edge register values.
      sel_valid_q <= 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
      cnt_q       <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q   <= S_FETCH;
            mem_req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          // An ack always wins, even in the cycle the timeout would fire.
          if (mem_ack) begin
            ir_q      <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= S_EXEC;
          end
`ifdef FETCH_CTRL_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_HALTED;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        S_EXEC: begin
          pc_q <= pc_d;
          if (op == OP_HALT) begin
            state_q <= S_HALTED;
          end else begin
            if (op == OP_SEL) begin
              a_q         <= ir_q[5];
              b_q         <= ir_q[4];
              imm_q       <= ir_q[3:0];
              sel_valid_q <= 1'b1;
            end
            state_q   <= run ? S_FETCH : S_IDLE;
            mem_req_q <= run;
          end
        end
        default: begin
          // HALTED: only reset leaves this state.
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign a         = a_q;
  assign b         = b_q;
  assign imm       = imm_q;
  assign sel_valid = sel_valid_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALTED);
`ifdef FETCH_CTRL_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: single-instruction vector table, hand-written
// multi-cycle sequences, and random programs checked against an instruction-level model.
module tb_fetch_ctrl;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;
  logic          a;
  logic          b;
  logic          sel_valid;
  logic [3:0]    imm;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          err;

  fetch_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .a(a), .b(b), .sel_valid(sel_valid), .imm(imm), .pc(pc),
    .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder state
  logic [7:0] mem [256];
  int         cur_delay;
  int         wait_cnt;
  bit         rand_delay;
  bit         stray;
  bit         hs;
  logic [7:0] hs_addr;

  typedef struct {
    logic [7:0]    instr;
    logic          a;
    logic          b;
    logic [3:0]    imm;
    logic [AW-1:0] pc;
    logic          sel;
    logic          halted;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Drive the memory response for the current cycle, then advance to just after the next edge.
  task automatic cycle();
    hs = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= cur_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        hs        = 1'b1;
        hs_addr   = mem_addr;
        wait_cnt  = 0;
        if (rand_delay) cur_delay = $urandom_range(0, 3);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_ack   = stray && ($urandom_range(0, 1) == 1);
      mem_rdata = 8'($urandom);
      wait_cnt  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    run       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    wait_cnt  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs [9];

  // Instruction-level reference model state
  logic [7:0] mpc;
  logic       ma, mb, mhalt;
  logic [3:0] mimm;
  logic       msel;

  initial begin
    int bad;
    int found;
    int nsel_m, nsel_d, pending, cyc;
    logic [7:0] ins;

    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    cur_delay = 0; wait_cnt = 0; rand_delay = 0; stray = 0;

    vecs[0] = '{8'h60, 1'b1, 1'b0, 4'h0, 8'h01, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 1'b0, 1'b1, 4'hA, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 1'b1, 1'b1, 4'hF, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h85, 1'b0, 1'b0, 4'h0, 8'h05, 1'b0, 1'b0};
    vecs[6] = '{8'hBF, 1'b0, 1'b0, 4'h0, 8'h0F, 1'b0, 1'b0};
    vecs[7] = '{8'hC0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
    vecs[8] = '{8'hF7, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};

    // Reset state
    do_reset();
    check("reset_state", {mem_req, mem_addr, a, b, sel_valid, imm, pc, busy, halted, err}, 64'd0);

    // Single-instruction vectors from reset, zero-wait ack
    foreach (vecs[i]) begin
      fill_mem(8'h00);
      mem[0] = vecs[i].instr;
      cur_delay = 0;
      do_reset();
      run = 1'b1;
      cycle(); cycle(); cycle();
      check($sformatf("vec%0d", i),
            {a, b, imm, pc, sel_valid, halted, busy, mem_req, mem_addr},
            {vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, vecs[i].sel, vecs[i].halted,
             !vecs[i].halted, !vecs[i].halted, vecs[i].pc});
    end

    // SEL then JMP 5: strobe timing and next fetch address
    fill_mem(8'h00);
    mem[0] = 8'h60; mem[1] = 8'h85;
    cur_delay = 0;
    do_reset();
    run = 1'b1;
    cycle();
    check("t2_fetch0", {mem_req, mem_addr, sel_valid, busy}, {1'b1, 8'h00, 1'b0, 1'b1});
    cycle();
    check("t2_exec0", {mem_req, busy, sel_valid}, {1'b0, 1'b1, 1'b0});
    cycle();
    check("t2_sel", {sel_valid, a, b, imm, pc, mem_addr, mem_req}, {1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 8'h01, 1'b1});
    cycle();
    check("t2_strobe_one_cycle", sel_valid, 1'b0);
    cycle();
    check("t3_jmp", {pc, mem_addr, mem_req, sel_valid, a, b}, {8'h05, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0});

    // pc wrap: NOPs from 0 up to FF, then one more NOP returns to 0
    fill_mem(8'h00);
    cur_delay = 0;
    do_reset();
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 1200 && found == 0; i++) begin
      cycle();
      if (pc == 8'hFF && mem_req) found = 1;
    end
    check("wrap_reach_ff", found, 1);
    cycle(); cycle();
    check("wrap_to_zero", {pc, mem_addr, mem_req}, {8'h00, 8'h00, 1'b1});

    // Ack delayed 3 cycles: request held stable, nothing executes early
    fill_mem(8'h00);
    mem[0] = 8'h5A;
    cur_delay = 3;
    do_reset();
    run = 1'b1;
    cycle();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(mem_req && mem_addr == 8'h00 && !sel_valid && !a && !b && imm == 4'h0 && busy)) bad++;
      cycle();
      if (hs != (i == 3)) bad++;
    end
    check("t4_stable_during_wait", bad, 0);
    cycle();
    check("t4_after_ack", {a, b, imm, sel_valid, pc}, {1'b0, 1'b1, 4'hA, 1'b1, 8'h01});

    // run falls during a fetch: the fetch completes, EXEC runs, then IDLE
    fill_mem(8'h00);
    mem[0] = 8'h60;
    cur_delay = 3;
    do_reset();
    run = 1'b1;
    cycle();
    run = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("run_drop_exec", busy, 1'b1);
    cycle();
    check("run_drop_idle", {sel_valid, mem_req, busy, halted, pc}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h01});
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (mem_req || busy) bad++;
    end
    check("run_drop_stays_idle", bad, 0);

    // Ack arriving in the 15th FETCH cycle completes normally in every build
    fill_mem(8'h00);
    mem[0] = 8'h60;
    cur_delay = 14;
    do_reset();
    run = 1'b1;
    cycle();
    for (int i = 0; i < 15; i++) cycle();
    cycle();
    check("ack_at_limit", {err, halted, sel_valid, a, pc}, {1'b0, 1'b0, 1'b1, 1'b1, 8'h01});

    // HALT with run=1 holds, ignores run and stray acks; only reset exits
    fill_mem(8'h00);
    mem[0] = 8'hC0;
    cur_delay = 0;
    do_reset();
    run = 1'b1;
    cycle(); cycle(); cycle();
    check("halt_enter", {halted, busy, mem_req, pc}, {1'b1, 1'b0, 1'b0, 8'h00});
    stray = 1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (mem_req || busy || !halted) bad++;
    end
    stray = 0;
    check("halt_hold_20", bad, 0);
    rst = 1'b1;
    #1;
    check("halt_reset", {halted, busy, mem_req}, {1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    check("halt_restart", {mem_req, busy, mem_addr}, {1'b1, 1'b1, 8'h00});

    // Async reset in the middle of a fetch clears everything before the next edge
    fill_mem(8'h00);
    mem[0] = 8'h70;
    cur_delay = 0;
    do_reset();
    run = 1'b1;
    cycle(); cycle(); cycle();
    cur_delay = 50;
    cycle(); cycle();
    check("mid_fetch_pre", {mem_req, a, b, pc}, {1'b1, 1'b1, 1'b1, 8'h01});
    #2;
    rst = 1'b1;
    #1;
    check("mid_fetch_reset", {mem_req, mem_addr, a, b, sel_valid, imm, pc, busy, halted, err}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch with no ack at all
    fill_mem(8'h00);
    cur_delay = 1000;
    do_reset();
    run = 1'b1;
    cycle();
`ifdef FETCH_CTRL_TIMEOUT_EN
    for (int i = 0; i < 14; i++) cycle();
    check("timeout_before", {err, busy, halted, mem_req}, {1'b0, 1'b1, 1'b0, 1'b1});
    cycle();
    check("timeout_fire", {err, halted, busy, mem_req}, {1'b1, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) cycle();
    check("timeout_sticky", {err, halted}, {1'b1, 1'b1});
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (!mem_req || !busy || err || halted) bad++;
    end
    check("no_timeout_waits", bad, 0);
`endif

    // Random programs against the instruction-level model
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) begin
        ins = 8'($urandom);
        if (ins[7:6] == 2'b11 && $urandom_range(0, 7) != 0) ins[7:6] = 2'b00;
        mem[i] = ins;
      end
      rand_delay = 1;
      stray      = 1;
      cur_delay  = $urandom_range(0, 3);
      do_reset();
      run = 1'b1;
      mpc = 8'h00; ma = 1'b0; mb = 1'b0; mimm = 4'h0; mhalt = 1'b0; msel = 1'b0;
      nsel_m = 0; nsel_d = 0; pending = 0; cyc = 0;
      forever begin
        if (pending == 0 && (mhalt || cyc >= 300)) break;
        cycle();
        cyc++;
        if (sel_valid) nsel_d++;
        if (pending != 0) begin
          pending = 0;
          check($sformatf("rand%0d_retire", p),
                {pc, a, b, imm, sel_valid, halted},
                {mpc, ma, mb, mimm, msel, mhalt});
        end
        if (hs) begin
          check($sformatf("rand%0d_fetch_addr", p), hs_addr, mpc);
          ins  = mem[mpc];
          msel = 1'b0;
          case (ins[7:6])
            2'b00: mpc = mpc + 8'd1;
            2'b01: begin
              ma = ins[5]; mb = ins[4]; mimm = ins[3:0]; msel = 1'b1;
              mpc = mpc + 8'd1;
              nsel_m++;
            end
            2'b10: mpc = {4'h0, ins[3:0]};
            default: mhalt = 1'b1;
          endcase
          pending = 1;
        end
      end
      check($sformatf("rand%0d_sel_count", p), nsel_d, nsel_m);
    end
    rand_delay = 0;
    stray      = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
